alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares the single combinational ALU of the basic processor between two requesters: the core datapath (port 0) and an auxiliary engine (port 1), e.g. a test/DMA sequencer.
- Arbitrates round-robin and drives the ALU operand, opcode and immediate inputs from the granted requester.
- Registers the ALU `Out`/`Branch` result into a one-entry response buffer with a valid/ready handshake.
- Keeps saturating per-requester issue counters for performance monitoring.

Parameters:
- DW, 8, operand/result width; must match the ALU data width.
- OPW, 4, opcode width; must match the ALU OP width.
- IMW, 3, immediate width; must match the ALU Im width.
- CNT_W, 16, width of each per-requester issue counter.
- IDLE_OP, 4'b0000, opcode driven to the ALU when no request is granted.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OPW  requester 0 ALU opcode.
- req0_a  input  DW  requester 0 InputA.
- req0_b  input  DW  requester 0 InputB.
- req0_im  input  IMW  requester 0 immediate.
- req1_valid / req1_ready / req1_op / req1_a / req1_b / req1_im: same as port 0, for requester 1.
- alu_op  output  OPW  to ALU OP.
- alu_a  output  DW  to ALU InputA.
- alu_b  output  DW  to ALU InputB.
- alu_im  output  IMW  to ALU Im.
- alu_out  input  DW  from ALU Out.
- alu_branch  input  1  from ALU Branch.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester index the result belongs to.
- rsp_data  output  DW  registered ALU result.
- rsp_branch  output  1  registered ALU Branch.
- stat_clr  input  1  synchronous clear of both counters.
- cnt0  output  CNT_W  ops issued for requester 0, saturating.
- cnt1  output  CNT_W  ops issued for requester 1, saturating.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_branch=0, cnt0=cnt1=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
  - Reset mid-operation discards any buffered response; no partial handshake survives.
- Issue permission:
  - can_issue = !rsp_valid || rsp_ready. A full buffer being drained in the same cycle still accepts a new op (zero-bubble).
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant = ~last.
  - reqN_ready = can_issue && grant==N && reqN_valid. At most one ready is high per cycle.
- ALU drive (combinational):
  - With a grant, alu_op/alu_a/alu_b/alu_im equal the granted requester's fields.
  - Otherwise alu_op=IDLE_OP and alu_a=alu_b=alu_im=0.
- Capture: on the rising edge where a handshake occurs:
  - rsp_data<=alu_out, rsp_branch<=alu_branch, rsp_id<=grant, rsp_valid<=1, last<=grant.
- Latency:
  - Handshake in cycle N, response visible in cycle N+1.
  - Sustained throughput is 1 op/cycle while rsp_ready=1.
- Drain:
  - rsp_valid && rsp_ready with no new handshake: rsp_valid<=0.
  - rsp_data/rsp_branch/rsp_id hold their last values.
- Backpressure:
  - rsp_valid && !rsp_ready: no grant is issued; response outputs stay stable.
  - Requesters must hold valid and payload stable until ready; the block does not check this.
- Pointer: last changes only on a handshake. Idle cycles and stalls do not rotate priority.
- Counters:
  - Increment the granted requester's counter on each handshake; hold at all-ones (saturate).
  - stat_clr has priority over an increment in the same cycle; the result is 0.
- Each ALU operation is single-cycle combinational; no multi-cycle ops exist.

Test Plan:
- Reset, then req0 ADD a=3,b=5 with rsp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 rsp_valid=1, rsp_id=0, rsp_data=8; cnt0=1.
- Both requesters valid continuously for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; cnt0=cnt1=3.
- req1 NEQ a=7,b=7 issued, then rsp_ready=0 for 4 cycles with req0 valid -> rsp_data=0 and rsp_id=1 held; req0_ready=0 throughout; req0 is accepted on the cycle rsp_ready rises.
- BNZ a=0x10 from req0 -> rsp_branch=1; BNZ a=0 -> rsp_branch=0; no valid requester -> alu_op=IDLE_OP and operands 0.
- Assert Reset while rsp_valid=1 and both requesters are valid -> rsp_valid=0 immediately; after release, req0 is granted first.
- Preload by 2^CNT_W+2 req0 ops (CNT_W=4 build) -> cnt0 holds 15; stat_clr pulsed together with a handshake -> cnt0=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Shares one combinational ALU between two requesters (core datapath on
// port 0, auxiliary engine on port 1). A round-robin arbiter picks one
// requester per cycle and drives its opcode, operands and immediate onto
// the ALU. The ALU result is then registered into a one-entry response
// buffer that uses a valid/ready handshake. Saturating per-requester issue
// counters record how many operations each requester has issued.
//
// Ports
//   Clk, Reset            clock (rising edge); asynchronous active-high reset
//   reqN_valid/_ready     request handshake for requester N (N = 0, 1)
//   reqN_op/_a/_b/_im     opcode, InputA, InputB and immediate for requester N
//   alu_op/_a/_b/_im      drive to the shared ALU
//   alu_out, alu_branch   combinational result coming back from the ALU
//   rsp_valid/_ready      response buffer handshake
//   rsp_id                index of the requester that owns the buffered result
//   rsp_data, rsp_branch  registered ALU Out / Branch
//   stat_clr              synchronous clear of both issue counters
//   cnt0, cnt1            saturating issue counters
// -----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int DW    = 8,
  parameter int OPW   = 4,
  parameter int IMW   = 3,
  parameter int CNT_W = 16,
  parameter logic [OPW-1:0] IDLE_OP = 4'b0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [IMW-1:0]   req0_im,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [IMW-1:0]   req1_im,
  output logic [OPW-1:0]   alu_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [IMW-1:0]   alu_im,
  input  logic [DW-1:0]    alu_out,
  input  logic             alu_branch,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_branch,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [DW-1:0]    r_rsp_data;
  logic             r_rsp_branch;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_can_issue;
  logic w_any_vld;
  logic w_grant;
  logic w_hs;

  // A buffer being drained this cycle can take a new result (zero bubble).
  assign w_can_issue = !r_rsp_valid || rsp_ready;
  assign w_any_vld   = req0_valid || req1_valid;
  assign w_hs        = w_any_vld && w_can_issue;

  // Round-robin select: on contention the requester not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign req0_ready = w_hs && req0_valid && (w_grant == 1'b0);
  assign req1_ready = w_hs && req1_valid && (w_grant == 1'b1);

  // ALU drive: granted requester's fields, idle opcode and zeros otherwise.
  always_comb begin
    alu_op = IDLE_OP;
    alu_a  = {DW{1'b0}};
    alu_b  = {DW{1'b0}};
    alu_im = {IMW{1'b0}};
    if (w_hs) begin
      case (w_grant)
        1'b0: begin
          alu_op = req0_op;
          alu_a  = req0_a;
          alu_b  = req0_b;
          alu_im = req0_im;
        end
        1'b1: begin
          alu_op = req1_op;
          alu_a  = req1_a;
          alu_b  = req1_b;
          alu_im = req1_im;
        end
        default: begin
          alu_op = IDLE_OP;
          alu_a  = {DW{1'b0}};
          alu_b  = {DW{1'b0}};
          alu_im = {IMW{1'b0}};
        end
      endcase
    end else begin
      alu_op = IDLE_OP;
      alu_a  = {DW{1'b0}};
      alu_b  = {DW{1'b0}};
      alu_im = {IMW{1'b0}};
    end
  end

  // Response buffer: capture on handshake, clear valid on a pure drain.
  // Payload is left untouched on drain so the last result stays readable.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= {DW{1'b0}};
      r_rsp_branch <= 1'b0;
    end else if (w_hs) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant;
      r_rsp_data   <= alu_out;
      r_rsp_branch <= alu_branch;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Priority pointer: rotates only on an accepted operation. Reset to 1
  // so requester 0 wins the first contention.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last <= 1'b1;
    end else if (w_hs) begin
      r_last <= w_grant;
    end
  end

  // Issue counters: clear beats increment; hold at all-ones once reached.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (req0_ready && !(&r_cnt0)) begin
        r_cnt0 <= r_cnt0 + CNT_ONE;
      end
      if (req1_ready && !(&r_cnt1)) begin
        r_cnt1 <= r_cnt1 + CNT_ONE;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_branch = r_rsp_branch;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule
